// File: rtl/inert_seq_if.sv
// ---------------------------------------------------------------------------
// inert_seq_if
//   Bundle between the inertial command sequencer, the SPI monarch that it
//   drives, and the flight controller that reads the assembled rates.
//
//   SPI side      : wrt (pulse), cmd[15:0]   -> monarch
//                   done (sticky), rd_data[15:0] <- monarch
//   Rate side     : ptch_rt, roll_rt, yaw_rt (signed 16-bit), vld (pulse),
//                   cfg_done (level)
//   Optional      : ax, ay (present only when INERT_ACCEL_RD_EN is defined)
//
//   master modport : the sequencer (inert_seq)
//   slave modport  : the environment (SPI monarch + rate consumer)
// ---------------------------------------------------------------------------
interface inert_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [15:0] ptch_rt;
  logic [15:0] roll_rt;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        cfg_done;
`ifdef INERT_ACCEL_RD_EN
  logic [15:0] ax;
  logic [15:0] ay;
`endif

  modport master (
    input  done, rd_data,
    output wrt, cmd, ptch_rt, roll_rt, yaw_rt, vld, cfg_done
`ifdef INERT_ACCEL_RD_EN
    , output ax, ay
`endif
  );

  modport slave (
    output done, rd_data,
    input  wrt, cmd, ptch_rt, roll_rt, yaw_rt, vld, cfg_done
`ifdef INERT_ACCEL_RD_EN
    , input ax, ay
`endif
  );
endinterface

// File: rtl/inert_seq.sv
// ---------------------------------------------------------------------------
// inert_seq
//   Command sequencer in front of the SPI monarch. After a power-up delay it
//   writes the IMU configuration table once, then on every data-ready
//   interrupt it reads the rate bytes (low byte first) and publishes them as
//   signed 16-bit words together with a one-cycle vld strobe.
//
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     INT      in   IMU data-ready interrupt (asynchronous, synchronised here)
//     bus      master modport of inert_seq_if (wrt/cmd/done/rd_data and the
//              rate outputs vld, cfg_done, ptch_rt, roll_rt, yaw_rt[, ax, ay])
//
//   Parameters:
//     PWRUP_W  width of the power-up delay counter (config starts when it
//              saturates at all-ones)
//     NUM_CFG  number of configuration writes issued from the table
//
//   Build option:
//     INERT_ACCEL_RD_EN  extends each frame with ax/ay (10 bytes instead of 6)
// ---------------------------------------------------------------------------
module inert_seq #(
  parameter int PWRUP_W = 16,
  parameter int NUM_CFG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          INT,
  inert_seq_if.master   bus
);

`ifdef INERT_ACCEL_RD_EN
  localparam int NBYTES = 10;
`else
  localparam int NBYTES = 6;
`endif

  localparam logic [3:0] CFG_LAST = 4'(NUM_CFG - 1);
  localparam logic [3:0] RD_LAST  = 4'(NBYTES - 1);

  localparam logic [2:0] PWRUP = 3'd0;
  localparam logic [2:0] CFG   = 3'd1;
  localparam logic [2:0] CWAIT = 3'd2;
  localparam logic [2:0] IDLE  = 3'd3;
  localparam logic [2:0] RD    = 3'd4;
  localparam logic [2:0] RWAIT = 3'd5;
  localparam logic [2:0] VLD   = 3'd6;

  // Configuration write table.
  function automatic logic [15:0] cfg_word(input logic [3:0] i);
    logic [15:0] w;
    case (i)
      4'd0:    w = 16'h0D02;  // data-ready interrupt enable
      4'd1:    w = 16'h1062;  // accel 416 Hz
      4'd2:    w = 16'h1162;  // gyro 416 Hz
      4'd3:    w = 16'h1460;  // rounding on
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Read command for byte slot i: registers 0x22 upwards, read bit set,
  // so slot 0 -> A200, slot 1 -> A300, ... slot 9 -> AB00.
  function automatic logic [15:0] rd_word(input logic [3:0] i);
    logic [3:0] addr_lo;
    addr_lo = 4'h2 + i;
    return {4'hA, addr_lo, 8'h00};
  endfunction

  logic                  int_meta_q, int_s_q;
  logic [2:0]            state_q, state_d;
  logic [PWRUP_W-1:0]    cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic                  wrt_q, wrt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [8*NBYTES-1:0]   bytes_q, bytes_d;
  logic [15:0]           ptch_q, ptch_d;
  logic [15:0]           roll_q, roll_d;
  logic [15:0]           yaw_q, yaw_d;
  logic                  vld_q, vld_d;
  logic                  cfg_done_q, cfg_done_d;
`ifdef INERT_ACCEL_RD_EN
  logic [15:0]           ax_q, ax_d;
  logic [15:0]           ay_q, ay_d;
`endif

  // Only the register contents byte of the SPI read word is meaningful.
  logic [7:0] unused_rd_hi;
  assign unused_rd_hi = bus.rd_data[15:8];

  // done from the previous transaction may still be high while wrt is high,
  // so a completion is only accepted once our own wrt pulse has gone.
  logic xfer_done_s;
  assign xfer_done_s = bus.done & ~wrt_q;

  // Two-flop synchroniser for the asynchronous interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
    end
  end

  // Next-state logic for the sequencer FSM and its datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    bytes_d    = bytes_q;
    ptch_d     = ptch_q;
    roll_d     = roll_q;
    yaw_d      = yaw_q;
    vld_d      = 1'b0;
    cfg_done_d = cfg_done_q;
`ifdef INERT_ACCEL_RD_EN
    ax_d       = ax_q;
    ay_d       = ay_q;
`endif

    case (state_q)
      PWRUP: begin
        if (cnt_q == {PWRUP_W{1'b1}}) begin
          state_d = CFG;
          idx_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + PWRUP_W'(1);
        end
      end

      CFG: begin
        wrt_d   = 1'b1;
        cmd_d   = cfg_word(idx_q);
        state_d = CWAIT;
      end

      CWAIT: begin
        if (xfer_done_s) begin
          if (idx_q == CFG_LAST) begin
            cfg_done_d = 1'b1;
            idx_d      = 4'd0;
            state_d    = IDLE;
          end else begin
            idx_d      = idx_q + 4'd1;
            state_d    = CFG;
          end
        end else begin
          state_d = CWAIT;
        end
      end

      IDLE: begin
        if (int_s_q) begin
          idx_d   = 4'd0;
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end

      RD: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_word(idx_q);
        state_d = RWAIT;
      end

      RWAIT: begin
        if (xfer_done_s) begin
          bytes_d[{idx_q, 3'b000} +: 8] = bus.rd_data[7:0];
          if (idx_q == RD_LAST) begin
            state_d = VLD;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = RD;
          end
        end else begin
          state_d = RWAIT;
        end
      end

      // All outputs switch together with the vld strobe, so a frame in
      // progress never leaks partial data.
      VLD: begin
        ptch_d  = bytes_q[15:0];
        roll_d  = bytes_q[31:16];
        yaw_d   = bytes_q[47:32];
`ifdef INERT_ACCEL_RD_EN
        ax_d    = bytes_q[63:48];
        ay_d    = bytes_q[79:64];
`endif
        vld_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = PWRUP;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWRUP;
      cnt_q      <= {PWRUP_W{1'b0}};
      idx_q      <= 4'd0;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      bytes_q    <= {(8*NBYTES){1'b0}};
      ptch_q     <= 16'h0000;
      roll_q     <= 16'h0000;
      yaw_q      <= 16'h0000;
      vld_q      <= 1'b0;
      cfg_done_q <= 1'b0;
`ifdef INERT_ACCEL_RD_EN
      ax_q       <= 16'h0000;
      ay_q       <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      bytes_q    <= bytes_d;
      ptch_q     <= ptch_d;
      roll_q     <= roll_d;
      yaw_q      <= yaw_d;
      vld_q      <= vld_d;
      cfg_done_q <= cfg_done_d;
`ifdef INERT_ACCEL_RD_EN
      ax_q       <= ax_d;
      ay_q       <= ay_d;
`endif
    end
  end

  assign bus.wrt      = wrt_q;
  assign bus.cmd      = cmd_q;
  assign bus.ptch_rt  = ptch_q;
  assign bus.roll_rt  = roll_q;
  assign bus.yaw_rt   = yaw_q;
  assign bus.vld      = vld_q;
  assign bus.cfg_done = cfg_done_q;
`ifdef INERT_ACCEL_RD_EN
  assign bus.ax       = ax_q;
  assign bus.ay       = ay_q;
`endif

endmodule

// File: tb/tb_inert_seq.sv
// ---------------------------------------------------------------------------
// tb_inert_seq
//   Directed bench for inert_seq with a small SPI monarch responder
//   (done 20 clk after each wrt, read data from a per-register byte table).
// ---------------------------------------------------------------------------
module tb_inert_seq;

`ifdef INERT_ACCEL_RD_EN
  localparam int NB = 10;
`else
  localparam int NB = 6;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic INT;

  inert_seq_if bus ();

  inert_seq #(.PWRUP_W(4), .NUM_CFG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .INT   (INT),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Byte returned for register 0x2N is resp[N].
  logic [7:0]  resp [0:15];
  logic [15:0] cfg_tab [0:3];
  logic [15:0] rd_tab [0:9];

  // SPI responder state (written only by the responder process).
  logic [15:0] cmd_log [$];
  int          busy_cnt       = 0;
  int          overlap_err    = 0;
  int          edge_cnt       = 0;
  int          first_wrt_edge = -1;
  int          resp_cnt       = 0;
  logic [3:0]  cur_addr       = 4'h0;
  logic        cur_read       = 1'b0;

  // Output monitor state.
  int          vld_cnt      = 0;
  int          vld_wide_err = 0;
  int          chg_err      = 0;
  logic [15:0] prev_p = 16'h0, prev_r = 16'h0, prev_y = 16'h0;
  logic        prev_vld = 1'b0;

  // SPI monarch model; its log and counters restart at every reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done       <= 1'b0;
      bus.rd_data    <= 16'h0000;
      busy_cnt       = 0;
      edge_cnt       = 0;
      first_wrt_edge = -1;
      resp_cnt       = 0;
      cmd_log.delete();
    end else begin
      edge_cnt++;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.done    <= 1'b1;
          bus.rd_data <= cur_read ? {8'h00, resp[cur_addr]} : 16'h0000;
          resp_cnt++;
        end
      end
      if (bus.wrt) begin
        if (busy_cnt > 0) overlap_err++;
        if (first_wrt_edge < 0) first_wrt_edge = edge_cnt;
        cmd_log.push_back(bus.cmd);
        cur_addr = bus.cmd[11:8];
        cur_read = bus.cmd[15];
        busy_cnt = 20;
        bus.done <= 1'b0;
      end
    end
  end

  // Rate outputs may only move together with vld; vld is one cycle wide.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vld) vld_cnt++;
      if (bus.vld && prev_vld) vld_wide_err++;
      if (!bus.vld && ({bus.ptch_rt, bus.roll_rt, bus.yaw_rt} !== {prev_p, prev_r, prev_y}))
        chg_err++;
    end
    prev_p   = bus.ptch_rt;
    prev_r   = bus.roll_rt;
    prev_y   = bus.yaw_rt;
    prev_vld = bus.vld;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cfg(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.cfg_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_vld(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    int bad;

    cfg_tab[0] = 16'h0D02; cfg_tab[1] = 16'h1062;
    cfg_tab[2] = 16'h1162; cfg_tab[3] = 16'h1460;
    rd_tab[0] = 16'hA200; rd_tab[1] = 16'hA300; rd_tab[2] = 16'hA400;
    rd_tab[3] = 16'hA500; rd_tab[4] = 16'hA600; rd_tab[5] = 16'hA700;
    rd_tab[6] = 16'hA800; rd_tab[7] = 16'hA900; rd_tab[8] = 16'hAA00;
    rd_tab[9] = 16'hAB00;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    resp[2] = 8'h34; resp[3] = 8'h12; resp[4] = 8'h78;
    resp[5] = 8'h56; resp[6] = 8'hCD; resp[7] = 8'hAB;
    resp[8] = 8'h11; resp[9] = 8'h22; resp[10] = 8'h33; resp[11] = 8'h44;

    // ---- 1. reset values and configuration sequence ----
    rst_n = 1'b0;
    INT   = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_wrt",      32'(bus.wrt),      32'h0);
    check("rst_cmd",      32'(bus.cmd),      32'h0);
    check("rst_vld",      32'(bus.vld),      32'h0);
    check("rst_cfg_done", 32'(bus.cfg_done), 32'h0);
    check("rst_ptch",     32'(bus.ptch_rt),  32'h0);
    check("rst_roll",     32'(bus.roll_rt),  32'h0);
    check("rst_yaw",      32'(bus.yaw_rt),   32'h0);
    rst_n = 1'b1;

    wait_cfg(500, ok);
    check("cfg_done_timeout", 32'(ok), 32'h1);
    check("first_wrt_edge", 32'(first_wrt_edge), 32'd18);
    check("cfg_wr_count", 32'(cmd_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("cfg_cmd%0d", k), 32'(cmd_log[k]), 32'(cfg_tab[k]));

    // ---- 2. idle with INT low ----
    repeat (1000) @(negedge clk);
    check("idle_no_wrt", 32'(cmd_log.size()), 32'd4);
    check("idle_no_vld", 32'(vld_cnt), 32'd0);
    check("idle_cfg_done_hold", 32'(bus.cfg_done), 32'h1);

    // ---- 3. single interrupt pulse ----
    #2 INT = 1'b1;
    repeat (3) @(negedge clk);
    #2 INT = 1'b0;
    wait_vld(1000, ok);
    check("frame_vld_timeout", 32'(ok), 32'h1);
    check("frame_ptch", 32'(bus.ptch_rt), 32'h1234);
    check("frame_roll", 32'(bus.roll_rt), 32'h5678);
    check("frame_yaw",  32'(bus.yaw_rt),  32'hABCD);
`ifdef INERT_ACCEL_RD_EN
    check("frame_ax", 32'(bus.ax), 32'h2211);
    check("frame_ay", 32'(bus.ay), 32'h4433);
`endif
    check("frame_rd_count", 32'(cmd_log.size()), 32'(4 + NB));
    for (int k = 0; k < NB; k++)
      check($sformatf("frame_rd%0d", k), 32'(cmd_log[4 + k]), 32'(rd_tab[k]));
    repeat (300) @(negedge clk);
    check("single_vld_count", 32'(vld_cnt), 32'd1);
    check("no_early_change", 32'(chg_err), 32'd0);

    // ---- 4. INT held high: back-to-back frames ----
    base = vld_cnt;
    #2 INT = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (vld_cnt >= base + 3) begin
        ok = 1'b1;
        break;
      end
    end
    #2 INT = 1'b0;
    check("b2b_timeout", 32'(ok), 32'h1);
    repeat (400) @(negedge clk);
    check("b2b_reads_per_vld", 32'(cmd_log.size() - 4), 32'(NB * vld_cnt));
    bad = 0;
    for (int k = 4; k < cmd_log.size(); k++)
      if (cmd_log[k] !== rd_tab[(k - 4) % NB]) bad++;
    check("b2b_rd_order", 32'(bad), 32'd0);
    check("b2b_no_overlap", 32'(overlap_err), 32'd0);
    check("b2b_vld_width", 32'(vld_wide_err), 32'd0);
    check("b2b_no_early_change", 32'(chg_err), 32'd0);
    check("b2b_ptch", 32'(bus.ptch_rt), 32'h1234);

    // ---- 5. reset mid-frame, reconfigure, INT pending before cfg_done ----
    resp[2] = 8'h80; resp[3] = 8'hFF; resp[4] = 8'h01;
    resp[5] = 8'h00; resp[6] = 8'hFF; resp[7] = 8'h7F;
    base = resp_cnt;
    #2 INT = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (resp_cnt >= base + 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("midframe_timeout", 32'(ok), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ptch",     32'(bus.ptch_rt),  32'h0);
    check("mid_rst_roll",     32'(bus.roll_rt),  32'h0);
    check("mid_rst_yaw",      32'(bus.yaw_rt),   32'h0);
    check("mid_rst_cfg_done", 32'(bus.cfg_done), 32'h0);
    check("mid_rst_wrt",      32'(bus.wrt),      32'h0);
    check("mid_rst_cmd",      32'(bus.cmd),      32'h0);
    rst_n = 1'b1;
    wait_cfg(500, ok);
    check("recfg_timeout", 32'(ok), 32'h1);
    check("recfg_first_wrt_edge", 32'(first_wrt_edge), 32'd18);
    check("recfg_count", 32'(cmd_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("recfg_cmd%0d", k), 32'(cmd_log[k]), 32'(cfg_tab[k]));
    wait_vld(1000, ok);
    #2 INT = 1'b0;
    check("post_rst_vld_timeout", 32'(ok), 32'h1);
    check("post_rst_first_rd", 32'(cmd_log[4]), 32'hA200);
    check("neg_ptch", 32'(bus.ptch_rt), 32'hFF80);
    check("one_roll", 32'(bus.roll_rt), 32'h0001);
    check("max_yaw",  32'(bus.yaw_rt),  32'h7FFF);
    repeat (400) @(negedge clk);
    check("final_no_overlap", 32'(overlap_err), 32'd0);
    check("final_vld_width", 32'(vld_wide_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
